// File: rtl/systolic_tile_ctrl_if.sv
// Systolic tile controller bundle: host command/result handshake
// plus weight/activation buffer reads and array control lines.
interface systolic_tile_ctrl_if #(
  parameter int N_ROWS = 14,
  parameter int K_W    = 16
);

  localparam int RW = $clog2(N_ROWS + 1);
  localparam int AW = $clog2(N_ROWS);

  // host command side
  logic          start;
  logic          abort;
  logic [K_W-1:0] cfg_k;
  logic [RW-1:0] cfg_rows;
  logic          hold;
  logic          busy;
  logic          done;
  logic          err;

  // buffer read side
  logic          wb_rd_en;
  logic [AW-1:0] wb_rd_addr;
  logic          ab_rd_en;
  logic [K_W-1:0] ab_rd_addr;

  // array control side
  logic              sa_en;
  logic              sa_clr;
  logic              sa_load_weight;
  logic [N_ROWS-1:0] sa_row_en;
  logic              sa_a_zero;

  // result handshake
  logic res_valid;
  logic res_ready;

  modport master (
    output start,
    output abort,
    output cfg_k,
    output cfg_rows,
    output hold,
    output res_ready,
    input  busy,
    input  done,
    input  err,
    input  wb_rd_en,
    input  wb_rd_addr,
    input  ab_rd_en,
    input  ab_rd_addr,
    input  sa_en,
    input  sa_clr,
    input  sa_load_weight,
    input  sa_row_en,
    input  sa_a_zero,
    input  res_valid
  );

  modport slave (
    input  start,
    input  abort,
    input  cfg_k,
    input  cfg_rows,
    input  hold,
    input  res_ready,
    output busy,
    output done,
    output err,
    output wb_rd_en,
    output wb_rd_addr,
    output ab_rd_en,
    output ab_rd_addr,
    output sa_en,
    output sa_clr,
    output sa_load_weight,
    output sa_row_en,
    output sa_a_zero,
    output res_valid
  );

endinterface

// File: rtl/systolic_tile_ctrl.sv
// Systolic tile sequencer: clear, weight load, activation stream,
// pipeline drain and result handshake for one output tile.
module systolic_tile_ctrl #(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  parameter int K_W    = 16
) (
  input logic clk,
  input logic rst,
  systolic_tile_ctrl_if.slave bus
);

  localparam int RW = $clog2(N_ROWS + 1);
  localparam int AW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_ROWS + N_COLS);
  localparam int DRAIN_LEN = N_ROWS + N_COLS - 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD_W  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  logic [2:0]     state;
  logic [2:0]     state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [K_W-1:0] kcnt;
  logic [K_W-1:0] kcnt_n;
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_n;
  logic [RW-1:0]  rows_q;
  logic [RW-1:0]  rows_n;
  logic [N_ROWS-1:0] mask_n;

  logic cfg_ok;
  logic go;
  logic bad;
  logic issue;
  logic k_last;
  logic kill;

  logic          busy_q;
  logic          err_q;
  logic          clr_q;
  logic          wb_en_q;
  logic [AW-1:0] wb_addr_q;
  logic          lw_q;
  logic          sa_en_q;
  logic          az_q;
  logic          rv_q;
  logic [N_ROWS-1:0] row_q;

  assign cfg_ok = (bus.cfg_k != '0) &&
                  (bus.cfg_rows != '0) &&
                  (bus.cfg_rows <= RW'(N_ROWS));
  assign go     = (state == S_IDLE) && bus.start && cfg_ok;
  assign bad    = (state == S_IDLE) && bus.start && !cfg_ok;
  assign issue  = (state == S_COMPUTE) && !bus.hold;
  assign k_last = (kcnt == k_q - K_W'(1));
  assign kill   = (state != S_IDLE) && bus.abort;

  // next state and counter values; abort wins over every transition
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    kcnt_n  = kcnt;
    k_n     = k_q;
    rows_n  = rows_q;
    if (kill) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      kcnt_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state_n = S_CLEAR;
            k_n     = bus.cfg_k;
            rows_n  = bus.cfg_rows;
          end
        end
        S_CLEAR: begin
          state_n = S_LOAD_W;
          cnt_n   = '0;
        end
        S_LOAD_W: begin
          if (cnt == CW'(N_ROWS)) begin
            state_n = S_COMPUTE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_COMPUTE: begin
          if (issue) begin
            if (k_last) begin
              state_n = S_DRAIN;
              kcnt_n  = '0;
              cnt_n   = '0;
            end else begin
              kcnt_n = kcnt + K_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (cnt == CW'(DRAIN_LEN)) begin
            state_n = S_RESULT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          kcnt_n  = '0;
        end
      endcase
    end
  end

  // thermometer mask of the active rows for the coming cycle
  always_comb begin
    mask_n = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      mask_n[i] = (i < int'(rows_n));
    end
  end

  // state, counters and registered outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kcnt      <= '0;
      k_q       <= '0;
      rows_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      lw_q      <= 1'b0;
      sa_en_q   <= 1'b0;
      az_q      <= 1'b0;
      rv_q      <= 1'b0;
      row_q     <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      kcnt    <= kcnt_n;
      k_q     <= k_n;
      rows_q  <= rows_n;
      busy_q  <= (state_n != S_IDLE);
      err_q   <= bad;
      clr_q   <= (state_n == S_CLEAR);
      wb_en_q <= (state_n == S_LOAD_W) &&
                 (cnt_n < CW'(N_ROWS));
      if ((state_n == S_LOAD_W) && (cnt_n < CW'(N_ROWS))) begin
        wb_addr_q <= AW'(cnt_n);
      end else begin
        wb_addr_q <= '0;
      end
      lw_q    <= (state_n == S_LOAD_W) && (cnt_n != '0);
      sa_en_q <= (state_n == S_DRAIN) ||
                 ((state_n == S_COMPUTE) && issue);
      az_q    <= (state == S_DRAIN) && (state_n == S_DRAIN);
      rv_q    <= (state_n == S_RESULT);
      row_q   <= (state_n != S_IDLE) ? mask_n : '0;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
  assign bus.done           = rv_q && bus.res_ready &&
                              !bus.abort && !rst;
  assign bus.sa_clr         = clr_q;
  assign bus.wb_rd_en       = wb_en_q;
  assign bus.wb_rd_addr     = wb_addr_q;
  assign bus.sa_load_weight = lw_q;
  assign bus.ab_rd_en       = issue;
  assign bus.ab_rd_addr     = kcnt;
  assign bus.sa_en          = sa_en_q;
  assign bus.sa_a_zero      = az_q;
  assign bus.res_valid      = rv_q;
  assign bus.sa_row_en      = row_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl with a timeline model
// of expected outputs per cycle.
module tb_systolic_tile_ctrl;

  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int KW   = 16;
  localparam int NCYC = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_tile_ctrl_if #(.N_ROWS(NR), .K_W(KW)) bus ();

  systolic_tile_ctrl #(
    .N_ROWS(NR),
    .N_COLS(NC),
    .K_W(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // stimulus per cycle
  int st_v[NCYC];
  int st_k[NCYC];
  int st_r[NCYC];
  int hold_v[NCYC];
  int rdy_v[NCYC];
  int ab_v[NCYC];
  int rst_v[NCYC];

  // expected outputs per cycle
  int e_busy[NCYC];
  int e_done[NCYC];
  int e_err[NCYC];
  int e_clr[NCYC];
  int e_wb[NCYC];
  int e_wba[NCYC];
  int e_lw[NCYC];
  int e_ab[NCYC];
  int e_aba[NCYC];
  int e_sa[NCYC];
  int e_az[NCYC];
  int e_rv[NCYC];
  int e_row[NCYC];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit running = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit ok(input int c);
    return (c >= 0) && (c < NCYC);
  endfunction

  // Timeline of one accepted tile started (start sampled) at cycle s.
  // cut >= 0: abort/reset seen at cycle cut, everything later is zero.
  task automatic plan_tile(input int s, input int k, input int r,
                           input int cut);
    int t;
    int iss;
    int acc;
    if (ok(s + 1)) e_clr[s + 1] = 1;
    for (int i = 0; i < NR; i++) begin
      if (ok(s + 2 + i)) begin
        e_wb[s + 2 + i]  = 1;
        e_wba[s + 2 + i] = i;
      end
      if (ok(s + 3 + i)) e_lw[s + 3 + i] = 1;
    end
    t   = s + NR + 3;
    iss = 0;
    while (iss < k && t < NCYC - 1) begin
      e_aba[t] = iss;
      if (hold_v[t] == 0) begin
        e_ab[t]     = 1;
        e_sa[t + 1] = 1;
        iss++;
      end
      t++;
    end
    for (int j = 1; j <= NR + NC - 2; j++) begin
      if (ok(t + j)) begin
        e_sa[t + j] = 1;
        e_az[t + j] = 1;
      end
    end
    acc = t + NR + NC - 1;
    while (ok(acc) && rdy_v[acc] == 0) begin
      e_rv[acc] = 1;
      acc++;
    end
    if (ok(acc)) begin
      e_rv[acc]   = 1;
      e_done[acc] = 1;
    end
    for (int c = s + 1; c <= acc && c < NCYC; c++) begin
      e_busy[c] = 1;
      e_row[c]  = (1 << r) - 1;
    end
    if (cut >= 0) begin
      if (ok(cut)) e_done[cut] = 0;
      for (int c = cut + 1; c <= acc && c < NCYC; c++) begin
        e_busy[c] = 0; e_row[c] = 0; e_clr[c] = 0;
        e_wb[c] = 0; e_wba[c] = 0; e_lw[c] = 0;
        e_ab[c] = 0; e_aba[c] = 0; e_sa[c] = 0;
        e_az[c] = 0; e_rv[c] = 0; e_done[c] = 0;
      end
    end
  endtask

  task automatic set_start(input int c, input int k, input int r);
    st_v[c] = 1;
    st_k[c] = k;
    st_r[c] = r;
  endtask

  // per-cycle comparison against the model plus literal pins
  always @(negedge clk) begin
    if (running) begin
      chk("busy", bus.busy, e_busy[cyc]);
      chk("done", bus.done, e_done[cyc]);
      chk("err", bus.err, e_err[cyc]);
      chk("sa_clr", bus.sa_clr, e_clr[cyc]);
      chk("wb_rd_en", bus.wb_rd_en, e_wb[cyc]);
      chk("wb_rd_addr", bus.wb_rd_addr, e_wba[cyc]);
      chk("sa_load_weight", bus.sa_load_weight, e_lw[cyc]);
      chk("ab_rd_en", bus.ab_rd_en, e_ab[cyc]);
      chk("ab_rd_addr", bus.ab_rd_addr, e_aba[cyc]);
      chk("sa_en", bus.sa_en, e_sa[cyc]);
      chk("sa_a_zero", bus.sa_a_zero, e_az[cyc]);
      chk("res_valid", bus.res_valid, e_rv[cyc]);
      chk("sa_row_en", bus.sa_row_en, e_row[cyc]);
      chk("excl_en_lw", bus.sa_en & bus.sa_load_weight, 0);
      chk("excl_clr",
          bus.sa_clr & (bus.sa_en | bus.sa_load_weight), 0);
      if (cyc == 2)   chk("pin_rst_busy", bus.busy, 0);
      if (cyc == 4)   chk("pin_a_clr", bus.sa_clr, 1);
      if (cyc == 5)   chk("pin_a_wb0", bus.wb_rd_en, 1);
      if (cyc == 8)   chk("pin_a_wb3", bus.wb_rd_addr, 3);
      if (cyc == 9)   chk("pin_a_lw6", bus.sa_load_weight, 1);
      if (cyc == 10)  chk("pin_a_ab7", bus.ab_rd_en, 1);
      if (cyc == 19)  chk("pin_a_sa16", bus.sa_en, 1);
      if (cyc == 20)  chk("pin_a_done17", bus.done, 1);
      if (cyc == 21)  chk("pin_a_idle18", bus.busy, 0);
      if (cyc == 33)  chk("pin_b_hold", bus.ab_rd_en, 0);
      if (cyc == 34)  chk("pin_b_addr1", bus.ab_rd_addr, 1);
      if (cyc == 43)  chk("pin_b_done", bus.done, 1);
      if (cyc == 48)  chk("pin_c_err_k0", bus.err, 1);
      if (cyc == 50)  chk("pin_c_err_r5", bus.err, 1);
      if (cyc == 64)  chk("pin_d_abort_row", bus.sa_row_en, 0);
      if (cyc == 105) chk("pin_e_wait", bus.done, 0);
      if (cyc == 106) chk("pin_e_done", bus.done, 1);
      if (cyc == 114) chk("pin_f_rst_wb", bus.wb_rd_en, 0);
    end
  end

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      st_v[c] = 0; st_k[c] = 0; st_r[c] = 0;
      hold_v[c] = 0; rdy_v[c] = 1; ab_v[c] = 0; rst_v[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_clr[c] = 0;
      e_wb[c] = 0; e_wba[c] = 0; e_lw[c] = 0; e_ab[c] = 0;
      e_aba[c] = 0; e_sa[c] = 0; e_az[c] = 0; e_rv[c] = 0;
      e_row[c] = 0;
    end

    rst_v[0] = 1;
    rst_v[1] = 1;
    // (a) plain tile
    set_start(3, 3, 4);
    // (b) one stall cycle in compute
    set_start(25, 3, 4);
    hold_v[33] = 1;
    // (c) bad configurations
    set_start(47, 0, 4);
    set_start(49, 2, 5);
    set_start(51, 2, 0);
    // (d) abort in compute, bad start while busy, then a clean run
    set_start(55, 5, 2);
    set_start(60, 0, 4);
    ab_v[63] = 1;
    set_start(66, 2, 3);
    // (e) delayed acceptance, start while waiting
    set_start(86, 1, 1);
    for (int c = 86; c <= 105; c++) rdy_v[c] = 0;
    set_start(103, 2, 4);
    // (f) reset during weight load, then a run with stalls
    set_start(110, 2, 3);
    rst_v[113] = 1;
    set_start(117, 2, 4);
    hold_v[125] = 1;
    hold_v[130] = 1;

    plan_tile(3, 3, 4, -1);
    plan_tile(25, 3, 4, -1);
    e_err[48] = 1;
    e_err[50] = 1;
    e_err[52] = 1;
    plan_tile(55, 5, 2, 63);
    plan_tile(66, 2, 3, -1);
    plan_tile(86, 1, 1, -1);
    plan_tile(110, 2, 3, 113);
    plan_tile(117, 2, 4, -1);

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_k     = '0;
    bus.cfg_rows  = '0;
    bus.hold      = 1'b0;
    bus.res_ready = 1'b1;
    rst           = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc           = c;
      bus.start     = (st_v[c] != 0);
      bus.cfg_k     = KW'(st_k[c]);
      bus.cfg_rows  = 3'(st_r[c]);
      bus.hold      = (hold_v[c] != 0);
      bus.res_ready = (rdy_v[c] != 0);
      bus.abort     = (ab_v[c] != 0);
      rst           = (rst_v[c] != 0);
      running       = 1'b1;
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_tile_ctrl.md
SYSTOLIC_TILE_CTRL -- requirements
Module: systolic_tile_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_ROWS, 14, array rows
- N_COLS, 14, array columns
- K_W, 16, width of the activation-vector count
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, tile start request
- abort, in, 1, cancel current tile
- cfg_k, in, K_W, number of activation vectors, 1..2^K_W-1
- cfg_rows, in, $clog2(N_ROWS+1), active rows, 1..N_ROWS
- hold, in, 1, compute stall
- busy, out, 1, tile in progress
- done, out, 1, one-cycle completion pulse
- err, out, 1, one-cycle bad-config pulse
- wb_rd_en, out, 1, weight buffer read
- wb_rd_addr, out, $clog2(N_ROWS), weight row address
- ab_rd_en, out, 1, activation buffer read
- ab_rd_addr, out, K_W, activation vector index
- sa_en, out, 1, array compute enable
- sa_clr, out, 1, array accumulator clear
- sa_load_weight, out, 1, array weight-load enable
- sa_row_en, out, N_ROWS, per-row enable mask
- sa_a_zero, out, 1, force array activation input to zero
- res_valid, out, 1, accumulators final
- res_ready, in, 1, result consumer accepted
REQ-003 Clock/reset: one clock; reset is synchronous and active-high.

Function
REQ-004 States: IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN, RESULT.
REQ-005 IDLE, start=1, cfg_k!=0, 1<=cfg_rows<=N_ROWS: latch cfg_k and cfg_rows, go to CLEAR next cycle.
REQ-006 IDLE, start=1 with cfg_k=0 or cfg_rows out of range: err=1 for one cycle, remain IDLE.
REQ-007 start outside IDLE: ignored, no err.
REQ-008 busy=1 in every state except IDLE.
REQ-009 sa_row_en = low cfg_rows bits set; all zero in IDLE.
REQ-010 CLEAR: exactly 1 cycle, sa_clr=1, then LOAD_W.
REQ-011 LOAD_W, read issue: wb_rd_en=1 for N_ROWS consecutive cycles, wb_rd_addr 0..N_ROWS-1.
REQ-012 LOAD_W, load: read latency is 1, so sa_load_weight=1 exactly on the N_ROWS cycles following each read; state lasts N_ROWS+1 cycles, then COMPUTE.
REQ-013 COMPUTE, read issue: ab_rd_en=1 and ab_rd_addr increments from 0 on every cycle with hold=0.
REQ-014 COMPUTE, hold=1: ab_rd_en=0 and the address freezes.
REQ-015 COMPUTE, compute enable: sa_en is ab_rd_en delayed by 1 cycle (data-valid alignment).
REQ-016 COMPUTE exit: after cfg_k reads are issued, go to DRAIN; the trailing sa_en cycle for the last read occurs in the first DRAIN cycle.
REQ-017 DRAIN: sa_en=1 and sa_a_zero=1 for N_ROWS+N_COLS-2 cycles after the last data sa_en; hold is ignored; then RESULT.
REQ-018 RESULT: res_valid=1, all sa_* controls 0; on res_ready=1, done=1 that cycle and IDLE next cycle.
REQ-019 Mutual exclusion: sa_load_weight and sa_en are never both 1; sa_clr is never 1 together with either.
REQ-020 Counters: K_W-bit counters with no wrap; terminal compare at cfg_k-1.
REQ-021 abort=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no done; abort has priority over all transitions including res_ready.
REQ-022 Outputs are registered, with no combinational path from start or res_ready to sa_* signals.

Reset
REQ-023 rst=1: state IDLE, all counters 0, all outputs 0 (including sa_row_en=0 and res_valid=0) on the next edge.
REQ-024 rst in any state, mid-operation: same behaviour as REQ-023; the tile is discarded.

Verification
REQ-025 Bench uses N_ROWS=N_COLS=4 and covers scenarios a-f:
- (a) start, cfg_k=3, cfg_rows=4, res_ready=1 -> clr@1; wb reads@2-5 addr 0-3; load_weight@3-6; ab reads@7-9 addr 0-2; sa_en@8-16; res_valid@17; done@17; busy low @18.
- (b) as (a) with hold=1 on cycle 8 -> ab_rd_addr 1 reissued cycle 9; all later events +1 cycle.
- (c) start with cfg_k=0, then cfg_rows=5 -> err pulse each time, busy stays 0.
- (d) abort during COMPUTE -> next cycle busy=0, all sa_* 0, no done; a new start runs normally.
- (e) res_ready held 0 for 5 cycles in RESULT -> res_valid held, done only on acceptance; start during RESULT ignored.
- (f) rst asserted in LOAD_W -> all outputs 0 next cycle; assertion check: sa_en&sa_load_weight never true across all runs.
